// File: rtl/synchronous_fifo.sv
// Synchronous first-word-fall-through FIFO with level flags and sticky
// overflow/underflow error flags. Pointers carry one extra bit so that a
// completely full FIFO is distinguishable from an empty one.
module synchronous_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int POINTER_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL  = 2**POINTER_WIDTH-1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     data_in_enable,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_out_acknowledge,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_out_valid,
  output logic [POINTER_WIDTH:0]   data_used,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2**POINTER_WIDTH;

  // Thresholds narrowed to the fill-level width so all compares are same-width.
  localparam logic [POINTER_WIDTH:0] FULL_LEVEL = {1'b1, {POINTER_WIDTH{1'b0}}};
  localparam logic [POINTER_WIDTH:0] AF_LEVEL   = ALMOST_FULL_LEVEL[POINTER_WIDTH:0];
  localparam logic [POINTER_WIDTH:0] AE_LEVEL   = ALMOST_EMPTY_LEVEL[POINTER_WIDTH:0];

  logic [POINTER_WIDTH:0]  wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH:0]  rd_ptr_q, rd_ptr_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_accept;
  logic                    rd_accept;

  // Level flags derive only from the registered pointers, so they never
  // glitch on request inputs and wrap cleanly with modulo subtraction.
  always_comb begin
    data_used      = wr_ptr_q - rd_ptr_q;
    full           = (data_used == FULL_LEVEL);
    empty          = (data_used == '0);
    data_out_valid = !empty;
    almost_full    = (data_used >= AF_LEVEL);
    almost_empty   = (data_used <= AE_LEVEL);
    data_out       = mem_q[rd_ptr_q[POINTER_WIDTH-1:0]];
    overflow       = overflow_q;
    underflow      = underflow_q;
  end

  // Accept decisions use pre-edge state only: a full FIFO refuses a write
  // even when a read frees a slot in the same cycle; flush discards both.
  always_comb begin
    wr_accept   = data_in_enable && !full && !flush;
    rd_accept   = data_out_acknowledge && !empty && !flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
      if (data_in_enable && full)        overflow_d  = 1'b1;
      if (data_out_acknowledge && empty) underflow_d = 1'b1;
    end
  end

  // Pointer and sticky-flag registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array has no reset; contents beyond the pointers are don't-care.
  always_ff @(posedge clock) begin
    if (wr_accept && reset_n) begin
      mem_q[wr_ptr_q[POINTER_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: doc/synchronous_fifo.md
SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter POINTER_WIDTH, default 4, address width; depth is 2**POINTER_WIDTH, and all entries are usable.
REQ-003 Parameter ALMOST_FULL_LEVEL, default 2**POINTER_WIDTH-1, fill level at or above which almost_full asserts; legal range 1..2**POINTER_WIDTH.
REQ-004 Parameter ALMOST_EMPTY_LEVEL, default 1, fill level at or below which almost_empty asserts; legal range 0..2**POINTER_WIDTH-1.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous clear of contents and sticky flags.
REQ-008 data_in_enable  input  1  write request.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 data_out_acknowledge  input  1  read request; pops the current head word.
REQ-011 data_out  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-012 data_out_valid  output  1  head word present (not empty).
REQ-013 data_used  output  POINTER_WIDTH+1  current fill level, 0..2**POINTER_WIDTH.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  level flags.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write and read pointers SHALL be POINTER_WIDTH+1 bits wide; the low bits address storage, and the MSB distinguishes full from empty on wrap-around.
REQ-017 data_used SHALL equal write pointer minus read pointer, modulo 2**(POINTER_WIDTH+1).
REQ-018 full = (data_used == 2**POINTER_WIDTH); empty = (data_used == 0); data_out_valid = !empty; all flags are combinational from registered pointers.
REQ-019 almost_full = (data_used >= ALMOST_FULL_LEVEL); almost_empty = (data_used <= ALMOST_EMPTY_LEVEL).
REQ-020 A write SHALL be accepted iff data_in_enable && !full && !flush; the word is stored at the write address and the write pointer increments at the same edge.
REQ-021 A read SHALL be accepted iff data_out_acknowledge && !empty && !flush; the read pointer increments at that edge.
REQ-022 A simultaneous accepted read and write SHALL leave data_used unchanged.
REQ-023 When full, a write SHALL be refused even if a read occurs in the same cycle: no pass-through, evaluated on pre-edge state.
REQ-024 When empty, data_out_acknowledge SHALL be ignored, and a word written in cycle N SHALL appear on data_out with data_out_valid=1 after edge N (one-cycle write-to-read latency).
REQ-025 data_out SHALL combinationally present the storage entry at the read address; its value is don't-care while empty.
REQ-026 overflow SHALL set at the edge where data_in_enable && full && !flush, and SHALL hold until flush or reset.
REQ-027 underflow SHALL set at the edge where data_out_acknowledge && empty && !flush, and SHALL hold until flush or reset.
REQ-028 flush SHALL have priority: at its edge both pointers, overflow and underflow clear; concurrent requests are discarded and do not set error flags.
REQ-029 Pointers SHALL wrap from 2**(POINTER_WIDTH+1)-1 to 0 without a data or flag glitch.
REQ-030 Storage SHALL be a register or RAM array without reset; contents are not cleared by reset or flush.

Reset
REQ-031 reset_n low SHALL immediately, independent of clock, force both pointers to 0 and overflow and underflow to 0.
REQ-032 Output values in reset SHALL be: data_used=0, empty=1, data_out_valid=0, full=0, almost_empty=1, almost_full=0.
REQ-033 Deassertion mid-operation SHALL resume from the empty state; no request is accepted on a clock edge where reset_n is low.

Verification (DATA_WIDTH=8, POINTER_WIDTH=2, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1)
REQ-034 Write 0x11,0x22,0x33,0x44 on four edges -> data_used 1,2,3,4; almost_full at 3; full at 4; almost_empty deasserts at 2; data_out=0x11 throughout.
REQ-035 Full, then write 0x55 together with acknowledge -> 0x11 popped, 0x55 refused, data_used=3, overflow=1; drain -> 0x22,0x33,0x44, then empty=1.
REQ-036 Empty, then acknowledge -> underflow=1, data_used stays 0; write 0xA5 -> next cycle data_out=0xA5, data_out_valid=1.
REQ-037 Stream 20 words with write and read in the same cycle after one pre-fill -> order preserved across pointer wrap, data_used constant at 1.
REQ-038 Three words stored with overflow set, then flush with write and acknowledge -> data_used=0, empty=1, overflow=0, no word accepted.
REQ-039 Async reset pulse between clock edges with two words stored -> outputs match REQ-032 before the next edge.
